// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the W_* bus arbiter and its round-robin picker.
//   arb_state_e : arbiter FSM states (IDLE -> BUS -> RELEASE -> IDLE)
//   DEF_ADDR_W / DEF_DATA_W : default bus widths, also used by the FETCH path
//   TIMER_W     : width of the no-acknowledge timeout counter
//   idx_w()     : width of an index into n requesters (at least 1 bit)
// This package replaces the former bus_defs.vh include; encodings are unchanged.
package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_BUS     = 2'd1,
        ARB_RELEASE = 2'd2
    } arb_state_e;

    localparam int unsigned DEF_ADDR_W = 32;
    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned TIMER_W    = 16;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   req_i   : request vector, one bit per requester
//   last_i  : index of the requester served most recently
//   valid_o : at least one request present
//   idx_o   : first requesting index scanning last_i+1, last_i+2, ... mod N
// Intended for reuse by interrupt/DMA schedulers.
module rr_pick #(
    parameter int unsigned N  = 2,
    parameter int unsigned IW = 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic          valid_o,
    output logic [IW-1:0] idx_o
);

    logic [IW-1:0] cand;

    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        // k = N wraps back to last_i itself, so a lone requester re-wins.
        for (int unsigned k = 1; k <= N; k++) begin
            cand = IW'((32'(last_i) + k) % N);
            if (!valid_o && req_i[cand]) begin
                valid_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing the single W_* memory bus between NUM_MASTERS
// requesters (FETCH path, store path, future DMA). One transaction in flight;
// a TIMEOUT-cycle watchdog completes a transaction with m_err if the slave
// never answers.
// Ports:
//   clk, W_RST        : clock (posedge), asynchronous active-high reset
//   m_req/m_write     : per-master request and direction (1 = write)
//   m_addr/m_wdata    : flattened per-master address / write data
//   m_ack/m_err       : one-cycle completion pulse / timeout flag to the grantee
//   m_rdata           : shared read data, valid with m_ack of a read
//   grant_id, busy    : current/last grantee; high in BUS or RELEASE
//   W_ADDR/W_DATA_O/W_WRITE/W_STB : registered bus outputs
//   W_DATA_I/W_ACK    : slave read data and completion
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned TIMEOUT     = 255,
    localparam int unsigned GW         = idx_w(NUM_MASTERS)
) (
    input  logic                          clk,
    input  logic                          W_RST,
    input  logic [NUM_MASTERS-1:0]        m_req,
    input  logic [NUM_MASTERS-1:0]        m_write,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
    output logic [NUM_MASTERS-1:0]        m_ack,
    output logic [NUM_MASTERS-1:0]        m_err,
    output logic [DATA_W-1:0]             m_rdata,
    output logic [GW-1:0]                 grant_id,
    output logic                          busy,
    output logic [ADDR_W-1:0]             W_ADDR,
    output logic [DATA_W-1:0]             W_DATA_O,
    output logic                          W_WRITE,
    output logic                          W_STB,
    input  logic [DATA_W-1:0]             W_DATA_I,
    input  logic                          W_ACK
);

    localparam logic [TIMER_W-1:0] TMO_LAST = TIMER_W'(TIMEOUT - 1);

    arb_state_e                state_q, state_d;
    logic [TIMER_W-1:0]        timer_q, timer_d;
    logic [GW-1:0]             last_q, last_d;
    logic [GW-1:0]             grant_q, grant_d;
    logic [ADDR_W-1:0]         addr_q, addr_d;
    logic [DATA_W-1:0]         wdata_q, wdata_d;
    logic                      write_q, write_d;
    logic                      stb_q, stb_d;
    logic [NUM_MASTERS-1:0]    ack_q, ack_d;
    logic [NUM_MASTERS-1:0]    err_q, err_d;
    logic [DATA_W-1:0]         rdata_q, rdata_d;

    logic                      pick_valid;
    logic [GW-1:0]             pick_idx;

    rr_pick #(
        .N  (NUM_MASTERS),
        .IW (GW)
    ) u_pick (
        .req_i   (m_req),
        .last_i  (last_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    always_ff @(posedge clk or posedge W_RST) begin
        if (W_RST) begin
            state_q <= ARB_IDLE;
            timer_q <= '0;
            last_q  <= GW'(NUM_MASTERS - 1);
            grant_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            stb_q   <= 1'b0;
            ack_q   <= '0;
            err_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            stb_q   <= stb_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        last_d  = last_q;
        grant_d = grant_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        write_d = write_q;
        stb_d   = stb_q;
        ack_d   = ack_q;
        err_d   = err_q;
        rdata_d = rdata_q;

        unique case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    addr_d  = m_addr[pick_idx*ADDR_W +: ADDR_W];
                    wdata_d = m_wdata[pick_idx*DATA_W +: DATA_W];
                    write_d = m_write[pick_idx];
                    stb_d   = 1'b1;
                    grant_d = pick_idx;
                    timer_d = '0;
                    state_d = ARB_BUS;
                end
            end
            ARB_BUS: begin
                timer_d = timer_q + 1'b1;
                // Acknowledge is checked first so it wins over a same-cycle timeout.
                if (W_ACK) begin
                    stb_d          = 1'b0;
                    write_d        = 1'b0;
                    ack_d[grant_q] = 1'b1;
                    if (!write_q) begin
                        rdata_d = W_DATA_I;
                    end
                    last_d  = grant_q;
                    state_d = ARB_RELEASE;
                end else if (timer_q == TMO_LAST) begin
                    stb_d          = 1'b0;
                    ack_d[grant_q] = 1'b1;
                    err_d[grant_q] = 1'b1;
                    last_d         = grant_q;
                    state_d        = ARB_RELEASE;
                end
            end
            ARB_RELEASE: begin
                ack_d   = '0;
                err_d   = '0;
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    assign m_ack    = ack_q;
    assign m_err    = err_q;
    assign m_rdata  = rdata_q;
    assign grant_id = grant_q;
    assign busy     = (state_q == ARB_BUS) || (state_q == ARB_RELEASE);
    assign W_ADDR   = addr_q;
    assign W_DATA_O = wdata_q;
    assign W_WRITE  = write_q;
    assign W_STB    = stb_q;

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;

    localparam int NM  = 2;
    localparam int TMO = 8;

    logic              clk;
    logic              W_RST;
    logic [NM-1:0]     m_req;
    logic [NM-1:0]     m_write;
    logic [NM*32-1:0]  m_addr;
    logic [NM*32-1:0]  m_wdata;
    logic [NM-1:0]     m_ack;
    logic [NM-1:0]     m_err;
    logic [31:0]       m_rdata;
    logic [0:0]        grant_id;
    logic              busy;
    logic [31:0]       W_ADDR;
    logic [31:0]       W_DATA_O;
    logic              W_WRITE;
    logic              W_STB;
    logic [31:0]       W_DATA_I;
    logic              W_ACK;

    bus_arbiter #(
        .NUM_MASTERS (NM),
        .ADDR_W      (32),
        .DATA_W      (32),
        .TIMEOUT     (TMO)
    ) dut (
        .clk      (clk),
        .W_RST    (W_RST),
        .m_req    (m_req),
        .m_write  (m_write),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_ack    (m_ack),
        .m_err    (m_err),
        .m_rdata  (m_rdata),
        .grant_id (grant_id),
        .busy     (busy),
        .W_ADDR   (W_ADDR),
        .W_DATA_O (W_DATA_O),
        .W_WRITE  (W_WRITE),
        .W_STB    (W_STB),
        .W_DATA_I (W_DATA_I),
        .W_ACK    (W_ACK)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    // Reference model state: pending requests, per-master fields,
    // round-robin pointer and last delivered read data.
    logic [NM-1:0] pend;
    logic [31:0]   f_addr  [NM];
    logic [31:0]   f_wdata [NM];
    logic          f_write [NM];
    int            last_m;
    logic [31:0]   rdata_m;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic int pick(input logic [NM-1:0] p, input int last);
        for (int k = 1; k <= NM; k++) begin
            if (p[(last + k) % NM]) return (last + k) % NM;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input logic wr, input logic [31:0] a, input logic [31:0] wd);
        f_addr[i]  = a;
        f_wdata[i] = wd;
        f_write[i] = wr;
        pend[i]    = 1'b1;
        m_req[i]   = 1'b1;
        m_write[i] = wr;
        m_addr[i*32 +: 32]  = a;
        m_wdata[i*32 +: 32] = wd;
    endtask

    // Called at a negedge with the arbiter idle and requests already driven.
    // d: cycles of W_STB before the slave raises W_ACK (never: no ack at all).
    task automatic serve(input int d, input bit never, input logic [31:0] sdata,
                         output int g, output int start);
        int  hi;
        bit  err;
        g = pick(pend, last_m);
        start = cyc;
        if (g < 0) begin
            check("pick_valid", 64'd0, 64'd1);
            return;
        end
        if (!never && d + 1 <= TMO) begin
            hi  = d + 1;
            err = 1'b0;
        end else begin
            hi  = TMO;
            err = 1'b1;
        end
        tick();
        start = cyc;
        for (int c = 1; c <= hi; c++) begin
            check("stb_hi",   64'(W_STB),    64'd1);
            check("grant",    64'(grant_id), 64'(g));
            check("busy_bus", 64'(busy),     64'd1);
            check("w_addr",   64'(W_ADDR),   64'(f_addr[g]));
            check("w_data",   64'(W_DATA_O), 64'(f_wdata[g]));
            check("w_write",  64'(W_WRITE),  64'(f_write[g]));
            check("no_ack",   64'(m_ack),    64'd0);
            W_ACK    = (!never && c == d + 1);
            W_DATA_I = W_ACK ? sdata : 32'($urandom);
            tick();
        end
        W_ACK = 1'b0;
        if (!err && !f_write[g]) rdata_m = sdata;
        check("stb_lo",  64'(W_STB), 64'd0);
        check("ack",     64'(m_ack), 64'(1 << g));
        check("err",     64'(m_err), err ? 64'(1 << g) : 64'd0);
        check("rdata",   64'(m_rdata), 64'(rdata_m));
        check("busy_rl", 64'(busy),  64'd1);
        if (!err) check("wr_clr", 64'(W_WRITE), 64'd0);
        m_req[g] = 1'b0;
        pend[g]  = 1'b0;
        last_m   = g;
        tick();
        check("ack_end",  64'(m_ack),    64'd0);
        check("err_end",  64'(m_err),    64'd0);
        check("busy_idl", 64'(busy),     64'd0);
        check("gid_hold", 64'(grant_id), 64'(g));
    endtask

    initial begin
        int g, s0, s1;
        W_RST    = 1'b1;
        m_req    = '0;
        m_write  = '0;
        m_addr   = '0;
        m_wdata  = '0;
        W_DATA_I = '0;
        W_ACK    = 1'b0;
        pend     = '0;
        last_m   = NM - 1;
        rdata_m  = '0;
        for (int i = 0; i < NM; i++) begin
            f_addr[i] = '0; f_wdata[i] = '0; f_write[i] = 1'b0;
        end

        // Reset state
        tick(); tick();
        check("rst_stb",   64'(W_STB),    64'd0);
        check("rst_ack",   64'(m_ack),    64'd0);
        check("rst_err",   64'(m_err),    64'd0);
        check("rst_rdata", 64'(m_rdata),  64'd0);
        check("rst_gid",   64'(grant_id), 64'd0);
        check("rst_busy",  64'(busy),     64'd0);
        check("rst_addr",  64'(W_ADDR),   64'd0);
        check("rst_wdat",  64'(W_DATA_O), 64'd0);
        check("rst_wr",    64'(W_WRITE),  64'd0);
        W_RST = 1'b0;
        tick();

        // Single read, slave answers after 2 cycles
        set_req(0, 1'b0, 32'h100, 32'h0);
        serve(2, 1'b0, 32'hDEADBEEF, g, s0);
        check("t1_grant", 64'(g), 64'd0);
        check("t1_rdata", 64'(m_rdata), 64'hDEADBEEF);

        // Write from master 1, read data must stay
        set_req(1, 1'b1, 32'h200, 32'h12345678);
        serve(1, 1'b0, 32'hCAFEF00D, g, s0);
        check("t2_grant", 64'(g), 64'd1);
        check("t2_rdata", 64'(m_rdata), 64'hDEADBEEF);

        // Both request continuously, immediate ack: 0,1,0,1 three cycles apart
        set_req(0, 1'b0, 32'h10, 32'h0);
        set_req(1, 1'b0, 32'h14, 32'h0);
        s1 = 0;
        for (int n = 0; n < 4; n++) begin
            serve(0, 1'b0, 32'(32'hA0 + n), g, s0);
            check("t3_order", 64'(g), 64'(n % 2));
            if (n > 0) check("t3_space", 64'(s0 - s1), 64'd3);
            s1 = s0;
            set_req(g, 1'b0, 32'(32'h10 + 4 * g), 32'h0);
        end
        // Drain the two outstanding requests
        serve(0, 1'b0, 32'h1111, g, s0);
        serve(0, 1'b0, 32'h2222, g, s0);

        // Timeout: slave silent, next request still served
        set_req(0, 1'b0, 32'h400, 32'h0);
        serve(0, 1'b1, 32'h0, g, s0);
        set_req(0, 1'b0, 32'h404, 32'h0);
        serve(0, 1'b0, 32'h5555AAAA, g, s0);
        check("t4_after", 64'(m_rdata), 64'h5555AAAA);

        // Ack in the timeout cycle wins; ack one cycle later is too late
        set_req(1, 1'b0, 32'h500, 32'h0);
        serve(TMO - 1, 1'b0, 32'h0BADCAFE, g, s0);
        set_req(0, 1'b0, 32'h504, 32'h0);
        serve(TMO, 1'b0, 32'h77777777, g, s0);

        // W_ACK pulsed while idle is ignored
        W_ACK = 1'b1;
        tick();
        W_ACK = 1'b0;
        tick();
        check("t5_idle_ack",  64'(m_ack), 64'd0);
        check("t5_idle_busy", 64'(busy),  64'd0);
        check("t5_idle_stb",  64'(W_STB), 64'd0);

        // Reset mid-transaction: last served is 0, master 1 in flight
        set_req(0, 1'b0, 32'h600, 32'h0);
        serve(0, 1'b0, 32'h600D600D, g, s0);
        set_req(1, 1'b0, 32'h700, 32'h0);
        tick();
        check("t6_stb", 64'(W_STB), 64'd1);
        tick(); tick();
        #2 W_RST = 1'b1;
        #1;
        check("t6_stb0",  64'(W_STB),    64'd0);
        check("t6_ack0",  64'(m_ack),    64'd0);
        check("t6_err0",  64'(m_err),    64'd0);
        check("t6_busy0", 64'(busy),     64'd0);
        check("t6_gid0",  64'(grant_id), 64'd0);
        check("t6_rd0",   64'(m_rdata),  64'd0);
        m_req   = '0;
        pend    = '0;
        last_m  = NM - 1;
        rdata_m = '0;
        tick();
        W_RST = 1'b0;
        tick();
        set_req(0, 1'b0, 32'h800, 32'h0);
        set_req(1, 1'b0, 32'h804, 32'h0);
        serve(0, 1'b0, 32'h13579BDF, g, s0);
        check("t6_prio", 64'(g), 64'd0);
        serve(0, 1'b0, 32'h2468ACE0, g, s0);

        // Randomized traffic against the model
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < NM; i++) begin
                if (!pend[i] && ($urandom_range(0, 2) != 0))
                    set_req(i, 1'($urandom_range(0, 1)), 32'($urandom), 32'($urandom));
            end
            if (pend == '0)
                set_req(int'($urandom_range(0, NM - 1)), 1'b0, 32'($urandom), 32'($urandom));
            W_ACK = 1'($urandom_range(0, 1));
            serve(int'($urandom_range(0, 9)), ($urandom_range(0, 7) == 0), 32'($urandom), g, s0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
